// File: rtl/mc_control_fsm.sv
// -----------------------------------------------------------------------------
// mc_control_fsm
//
// Main controller for a multicycle MIPS datapath. One instruction is in
// flight at a time. The controller walks a fixed state sequence per opcode
// and drives the shared ALU, PC, IR, memory and register-file controls as a
// Moore decode of the current state. The one exception is pc_write in the
// branch state, which depends on the ALU flags in that same cycle.
//
// Optional feature (compile-time macro): INSTR_CNT_EN
//   When defined, an instr_cnt output counts retired instructions. The count
//   advances on the last state of each instruction and wraps at 2^CNT_W.
//   When undefined, the port and the counter do not exist.
//
// Parameters
//   ST_W   width of the state register and the debug state port (>= 4)
//   CNT_W  width of the retired-instruction counter (INSTR_CNT_EN only)
//
// Ports
//   clk           in   system clock; all state updates on the rising edge
//   rst_n         in   synchronous active-low reset, sampled on the rising edge
//   opcode        in   IR[31:26]
//   funct         in   IR[5:0]
//   alu_zero      in   ALU result == 0 (same cycle)
//   alu_positive  in   ALU result > 0, signed (same cycle)
//   pc_write      out  PC load enable
//   pc_src        out  00 ALU result, 01 ALU result register, 10 jump target
//   iord          out  memory address: 0 PC, 1 ALU result register
//   mem_read      out  memory read strobe
//   mem_write     out  memory write strobe
//   ir_write      out  IR load enable
//   reg_dst       out  write register: 0 rt, 1 rd
//   mem_to_reg    out  write data: 0 ALU result register, 1 MDR
//   reg_write     out  register file write enable
//   alu_src_a     out  0 PC, 1 rs
//   alu_src_b     out  00 rt, 01 const 4, 10 sext(imm), 11 sext(imm)<<2
//   alu_op        out  ALU operation code (NOP 1111 when the ALU is unused)
//   illegal       out  high while halted on an undecodable instruction
//   state         out  current state (debug)
//   instr_cnt     out  retired-instruction count (INSTR_CNT_EN only)
// -----------------------------------------------------------------------------
module mc_control_fsm #(
  parameter int ST_W  = 4,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [5:0]      opcode,
  input  logic [5:0]      funct,
  input  logic            alu_zero,
  input  logic            alu_positive,
  output logic            pc_write,
  output logic [1:0]      pc_src,
  output logic            iord,
  output logic            mem_read,
  output logic            mem_write,
  output logic            ir_write,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            reg_write,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [3:0]      alu_op,
  output logic            illegal,
  output logic [ST_W-1:0] state
`ifdef INSTR_CNT_EN
  ,
  output logic [CNT_W-1:0] instr_cnt
`endif
);

  // Elaboration-time sanity checks on the parameters.
  if (ST_W < 4) begin : g_st_w_check
    $error("mc_control_fsm: ST_W must be at least 4");
  end
  if (CNT_W < 1) begin : g_cnt_w_check
    $error("mc_control_fsm: CNT_W must be at least 1");
  end

  typedef enum logic [ST_W-1:0] {
    S_IF   = 0,
    S_ID   = 1,
    S_MADR = 2,
    S_MRD  = 3,
    S_MWB  = 4,
    S_MWR  = 5,
    S_EX   = 6,
    S_RWB  = 7,
    S_BR   = 8,
    S_JMP  = 9,
    S_AEX  = 10,
    S_AWB  = 11,
    S_HALT = 12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  state_e state_q, state_d;
  // Remembers lw vs sw from ID so the address state need not re-decode opcode.
  logic   is_lw_q, is_lw_d;

  function automatic logic funct_valid(input logic [5:0] fn);
    case (fn)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_NOR: funct_valid = 1'b1;
      default:                                       funct_valid = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] funct_alu_op(input logic [5:0] fn);
    case (fn)
      FN_ADD:  funct_alu_op = ALU_ADD;
      FN_SUB:  funct_alu_op = ALU_SUB;
      FN_AND:  funct_alu_op = ALU_AND;
      FN_OR:   funct_alu_op = ALU_OR;
      FN_SLT:  funct_alu_op = ALU_SLT;
      FN_NOR:  funct_alu_op = ALU_NOR;
      default: funct_alu_op = ALU_NOP;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IF;
      is_lw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      is_lw_q <= is_lw_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    is_lw_d    = is_lw_q;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = ALU_NOP;
    illegal    = 1'b0;

    case (state_q)
      S_IF: begin
        // Fetch and PC+4 in the same cycle.
        iord      = 1'b0;
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        pc_src    = 2'b00;
        alu_src_a = 1'b0;
        alu_src_b = 2'b01;
        alu_op    = ALU_ADD;
        state_d   = S_ID;
      end

      S_ID: begin
        // Speculatively compute the branch target into the ALU result register.
        alu_src_a = 1'b0;
        alu_src_b = 2'b11;
        alu_op    = ALU_ADD;
        is_lw_d   = (opcode == OP_LW);
        case (opcode)
          OP_RTYPE:               state_d = funct_valid(funct) ? S_EX : S_HALT;
          OP_LW, OP_SW:           state_d = S_MADR;
          OP_ADDI:                state_d = S_AEX;
          OP_BEQ, OP_BNE, OP_BGTZ: state_d = S_BR;
          OP_J:                   state_d = S_JMP;
          default:                state_d = S_HALT;
        endcase
      end

      S_MADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
        state_d   = is_lw_q ? S_MRD : S_MWR;
      end

      S_MRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        state_d  = S_MWB;
      end

      S_MWB: begin
        reg_dst    = 1'b0;
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = S_IF;
      end

      S_MWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        state_d   = S_IF;
      end

      S_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b00;
        alu_op    = funct_alu_op(funct);
        state_d   = S_RWB;
      end

      S_RWB: begin
        reg_dst    = 1'b1;
        mem_to_reg = 1'b0;
        reg_write  = 1'b1;
        state_d    = S_IF;
      end

      S_BR: begin
        // rs - rt; for bgtz rt is $0 so the ALU sees rs - 0 and the flags
        // describe rs itself. The target was computed in ID.
        alu_src_a = 1'b1;
        alu_src_b = 2'b00;
        alu_op    = ALU_SUB;
        pc_src    = 2'b01;
        pc_write  = ((opcode == OP_BEQ)  &&  alu_zero) ||
                    ((opcode == OP_BNE)  && !alu_zero) ||
                    ((opcode == OP_BGTZ) &&  alu_positive);
        state_d   = S_IF;
      end

      S_JMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        state_d  = S_IF;
      end

      S_AEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
        state_d   = S_AWB;
      end

      S_AWB: begin
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b1;
        state_d    = S_IF;
      end

      S_HALT: begin
        illegal = 1'b1;
        state_d = S_HALT;
      end

      default: begin
        // Unused encodings behave like HALT and fall into it.
        illegal = 1'b1;
        state_d = S_HALT;
      end
    endcase
  end

  assign state = state_q;

`ifdef INSTR_CNT_EN
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic             retire;

  // The final state of every legal instruction retires it; HALT never does.
  always_comb begin
    case (state_q)
      S_MWB, S_MWR, S_RWB, S_BR, S_JMP, S_AWB: retire = 1'b1;
      default:                                 retire = 1'b0;
    endcase
    instr_cnt_d = retire ? instr_cnt_q + 1'b1 : instr_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_cnt_q <= '0;
    end else begin
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_mc_control_fsm
//
// Table-driven bench for mc_control_fsm. Each table row gives the inputs held
// during one clock cycle and the state the controller must be in during that
// cycle. Control outputs are checked in every row against a per-state
// reference decode. A short hand-written sequence at the end covers the
// same-cycle dependence of pc_write on alu_zero in the branch state.
// With INSTR_CNT_EN defined the DUT uses CNT_W=4 and the retired-instruction
// count is tracked and checked each row, including the wrap after 17
// instructions.
// -----------------------------------------------------------------------------
module tb_mc_control_fsm;

`ifdef INSTR_CNT_EN
  localparam int TB_CNT_W = 4;
`else
  localparam int TB_CNT_W = 32;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       alu_zero;
  logic       alu_positive;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_op;
  logic       illegal;
  logic [3:0] state;
`ifdef INSTR_CNT_EN
  logic [TB_CNT_W-1:0] instr_cnt;
`endif

  always #5 clk = ~clk;

  mc_control_fsm #(
    .ST_W (4),
    .CNT_W(TB_CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .funct       (funct),
    .alu_zero    (alu_zero),
    .alu_positive(alu_positive),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .iord        (iord),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .reg_write   (reg_write),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .illegal     (illegal),
    .state       (state)
`ifdef INSTR_CNT_EN
    ,
    .instr_cnt   (instr_cnt)
`endif
  );

  typedef struct {
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic       p;
    int         st;   // expected state during this cycle
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add_row(input logic r, input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input logic p, input int st);
    vec_t v;
    v.rst_n = r; v.op = op; v.fn = fn; v.z = z; v.p = p; v.st = st;
    vecs.push_back(v);
  endtask

  // IF, ID, then up to three more states (negative entries are skipped).
  task automatic add_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input logic p, input int s2, input int s3, input int s4);
    add_row(1'b1, op, fn, z, p, 0);
    add_row(1'b1, op, fn, z, p, 1);
    if (s2 >= 0) add_row(1'b1, op, fn, z, p, s2);
    if (s3 >= 0) add_row(1'b1, op, fn, z, p, s3);
    if (s4 >= 0) add_row(1'b1, op, fn, z, p, s4);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Reference decode, bit layout:
  // [17] pc_write [16:15] pc_src [14] iord [13] mem_read [12] mem_write
  // [11] ir_write [10] reg_dst [9] mem_to_reg [8] reg_write [7] alu_src_a
  // [6:5] alu_src_b [4:1] alu_op [0] illegal
  // m marks which bits matter in that state; enables, alu_op and illegal
  // always matter, mux selects only where the state uses them.
  task automatic exp_ctrl(input int st, input logic [5:0] op, input logic [5:0] fn,
                          input logic z, input logic p,
                          output logic [17:0] v, output logic [17:0] m);
    logic pw, io, mr, mw, iw, rd, m2r, rw, sa, ill;
    logic [1:0] ps, sb;
    logic [3:0] ao;
    logic c_ps, c_io, c_rd, c_m2r, c_sa, c_sb;
    pw = 0; io = 0; mr = 0; mw = 0; iw = 0; rd = 0; m2r = 0; rw = 0; sa = 0; ill = 0;
    ps = 2'b00; sb = 2'b00; ao = 4'b1111;
    c_ps = 0; c_io = 0; c_rd = 0; c_m2r = 0; c_sa = 0; c_sb = 0;
    case (st)
      0:  begin pw = 1; mr = 1; iw = 1; c_io = 1; c_sa = 1; sb = 2'b01; c_sb = 1;
                ao = 4'b0010; c_ps = 1; end
      1:  begin c_sa = 1; sb = 2'b11; c_sb = 1; ao = 4'b0010; end
      2:  begin sa = 1; c_sa = 1; sb = 2'b10; c_sb = 1; ao = 4'b0010; end
      3:  begin io = 1; c_io = 1; mr = 1; end
      4:  begin c_rd = 1; m2r = 1; c_m2r = 1; rw = 1; end
      5:  begin io = 1; c_io = 1; mw = 1; end
      6:  begin
            sa = 1; c_sa = 1; c_sb = 1;
            case (fn)
              6'h20: ao = 4'b0010;
              6'h22: ao = 4'b0110;
              6'h24: ao = 4'b0000;
              6'h25: ao = 4'b0001;
              6'h2a: ao = 4'b0111;
              6'h27: ao = 4'b1100;
              default: ao = 4'bxxxx;
            endcase
          end
      7:  begin rd = 1; c_rd = 1; c_m2r = 1; rw = 1; end
      8:  begin sa = 1; c_sa = 1; c_sb = 1; ao = 4'b0110; ps = 2'b01; c_ps = 1;
                pw = (op == 6'h04 && z) || (op == 6'h05 && !z) || (op == 6'h07 && p); end
      9:  begin ps = 2'b10; c_ps = 1; pw = 1; end
      10: begin sa = 1; c_sa = 1; sb = 2'b10; c_sb = 1; ao = 4'b0010; end
      11: begin c_rd = 1; c_m2r = 1; rw = 1; end
      default: ill = 1;
    endcase
    v = {pw, ps, io, mr, mw, iw, rd, m2r, rw, sa, sb, ao, ill};
    m = {1'b1, c_ps, c_ps, c_io, 1'b1, 1'b1, 1'b1, c_rd, c_m2r, 1'b1, c_sa, c_sb, c_sb,
         4'hf, 1'b1};
  endtask

  logic [17:0] act_ctrl;
  assign act_ctrl = {pc_write, pc_src, iord, mem_read, mem_write, ir_write, reg_dst,
                     mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, illegal};

  initial begin
    int marker;
    logic [17:0] ev, em;
    logic [TB_CNT_W-1:0] cnt_exp;

    // R-types: IF, ID, EX(6), RWB(7)
    add_instr(6'h00, 6'h20, 1'b0, 1'b0, 6, 7, -1);   // add
    add_instr(6'h00, 6'h22, 1'b1, 1'b1, 6, 7, -1);   // sub
    add_instr(6'h00, 6'h24, 1'b0, 1'b1, 6, 7, -1);   // and
    add_instr(6'h00, 6'h25, 1'b1, 1'b0, 6, 7, -1);   // or
    add_instr(6'h00, 6'h2a, 1'b0, 1'b0, 6, 7, -1);   // slt
    add_instr(6'h00, 6'h27, 1'b0, 1'b0, 6, 7, -1);   // nor
    add_instr(6'h23, 6'h15, 1'b0, 1'b0, 2, 3, 4);    // lw: MADR, MRD, MWB
    add_instr(6'h2b, 6'h00, 1'b1, 1'b1, 2, 5, -1);   // sw: MADR, MWR
    add_instr(6'h08, 6'h3f, 1'b0, 1'b0, 10, 11, -1); // addi: AEX, AWB
    add_instr(6'h04, 6'h00, 1'b1, 1'b0, 8, -1, -1);  // beq taken
    add_instr(6'h04, 6'h00, 1'b0, 1'b1, 8, -1, -1);  // beq not taken
    add_instr(6'h05, 6'h00, 1'b0, 1'b0, 8, -1, -1);  // bne taken
    add_instr(6'h05, 6'h00, 1'b1, 1'b0, 8, -1, -1);  // bne not taken
    add_instr(6'h07, 6'h00, 1'b0, 1'b1, 8, -1, -1);  // bgtz taken
    add_instr(6'h07, 6'h00, 1'b1, 1'b0, 8, -1, -1);  // bgtz not taken
    add_instr(6'h02, 6'h00, 1'b0, 1'b0, 9, -1, -1);  // j
    add_instr(6'h00, 6'h20, 1'b0, 1'b0, 6, 7, -1);   // add, 17th instruction
    marker = vecs.size();
    // Unknown R-type funct halts; one reset edge returns to IF.
    add_row(1'b1, 6'h00, 6'h21, 1'b0, 1'b0, 0);
    add_row(1'b1, 6'h00, 6'h21, 1'b0, 1'b0, 1);
    add_row(1'b1, 6'h00, 6'h21, 1'b0, 1'b0, 12);
    add_row(1'b0, 6'h00, 6'h21, 1'b0, 1'b0, 12);
    // lw aborted by reset in MRD: back to IF with no write-back.
    add_row(1'b1, 6'h23, 6'h00, 1'b0, 1'b0, 0);
    add_row(1'b1, 6'h23, 6'h00, 1'b0, 1'b0, 1);
    add_row(1'b1, 6'h23, 6'h00, 1'b0, 1'b0, 2);
    add_row(1'b0, 6'h23, 6'h00, 1'b0, 1'b0, 3);
    add_instr(6'h00, 6'h20, 1'b0, 1'b0, 6, 7, -1);
    // Illegal opcode: HALT for 10 cycles, reset on the last one.
    add_row(1'b1, 6'h3f, 6'h00, 1'b0, 1'b0, 0);
    add_row(1'b1, 6'h3f, 6'h00, 1'b0, 1'b0, 1);
    for (int i = 0; i < 10; i++) add_row((i == 9) ? 1'b0 : 1'b1, 6'h3f, 6'h00, 1'b1, 1'b1, 12);
    add_row(1'b1, 6'h00, 6'h20, 1'b0, 1'b0, 0);

    rst_n = 1'b0; opcode = 6'h00; funct = 6'h20; alu_zero = 1'b0; alu_positive = 1'b0;
    @(posedge clk);
    @(posedge clk);
    cnt_exp = '0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n; opcode = vecs[i].op; funct = vecs[i].fn;
      alu_zero = vecs[i].z; alu_positive = vecs[i].p;
      #1;
      chk($sformatf("row%0d state", i), 32'(state), 32'(vecs[i].st));
      exp_ctrl(vecs[i].st, vecs[i].op, vecs[i].fn, vecs[i].z, vecs[i].p, ev, em);
      chk($sformatf("row%0d ctrl st%0d", i, vecs[i].st), 32'(act_ctrl & em), 32'(ev & em));
`ifdef INSTR_CNT_EN
      chk($sformatf("row%0d instr_cnt", i), 32'(instr_cnt), 32'(cnt_exp));
      if (i == marker) chk("instr_cnt wrap after 17", 32'(instr_cnt), 32'd1);
      if (!vecs[i].rst_n) cnt_exp = '0;
      else if (vecs[i].st inside {4, 5, 7, 8, 9, 11}) cnt_exp = cnt_exp + 1'b1;
`endif
      $display("row %0d: rst_n=%0d op=%02h fn=%02h z=%0d p=%0d state=%0d ctrl=%05h",
               i, vecs[i].rst_n, vecs[i].op, vecs[i].fn, vecs[i].z, vecs[i].p, state, act_ctrl);
    end

    // Last row was IF with rst_n=1. Issue beq and flip alu_zero inside BR.
    @(negedge clk);
    opcode = 6'h04; funct = 6'h00; alu_zero = 1'b0; alu_positive = 1'b0;
    #1;
    chk("hand beq ID", 32'(state), 32'd1);
    @(negedge clk);
    #1;
    chk("hand BR state", 32'(state), 32'd8);
    chk("hand BR zero=0 pc_write", 32'(pc_write), 32'd0);
    alu_zero = 1'b1;
    #1;
    chk("hand BR zero=1 pc_write", 32'(pc_write), 32'd1);
    chk("hand BR pc_src", 32'(pc_src), 32'd1);
    $display("hand beq: state=%0d pc_write=%0d pc_src=%0d", state, pc_write, pc_src);
    @(negedge clk);
    #1;
    chk("hand after BR state", 32'(state), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
